// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: file-sequencer states and default widths.
package dmem_pkg;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_prio_arbiter.sv
// Fixed CPU-over-DMA priority with a DMA anti-starvation counter.
module dmem_prio_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_gnt,
    output logic dma_gnt
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    always_comb begin
        starved      = (starve_cnt_q == CNT_MAX);
        dma_gnt      = arb_en & dma_req & (starved | ~cpu_req);
        cpu_gnt      = arb_en & cpu_req & ~dma_gnt;
        starve_cnt_d = starve_cnt_q;
        // The count only measures CPU wins against a DMA that is actually waiting.
        if (!dma_req || dma_gnt) begin
            starve_cnt_d = '0;
        end else if (cpu_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between CPU and DMA ports and sequences file load/dump.
module data_memory_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              file_load,
    input  logic              file_dump,
    output logic              file_busy,
    output logic              file_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_read_file,
    output logic              mem_write_file,
    input  logic [DATA_W-1:0] mem_q
);

    state_e state_q, state_d;
    logic   pend_load_q, pend_load_d;
    logic   pend_dump_q, pend_dump_d;
    logic   file_done_q;
    logic   cpu_rvalid_q, dma_rvalid_q;
    logic   busy_raw;
    logic   arb_en;

    assign busy_raw = pend_load_q | pend_dump_q | (state_q != ST_IDLE);
    // A pending file op takes the whole IDLE cycle so the port grants stay out of its way.
    assign arb_en   = ~RESET & (state_q == ST_IDLE) & ~pend_load_q & ~pend_dump_q;

    dmem_prio_arbiter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk    (CLK),
        .reset  (RESET),
        .arb_en (arb_en),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .cpu_gnt(cpu_gnt),
        .dma_gnt(dma_gnt)
    );

    always_comb begin
        state_d     = state_q;
        pend_load_d = pend_load_q | (file_load & ~busy_raw);
        pend_dump_d = pend_dump_q | (file_dump & ~busy_raw);
        unique case (state_q)
            ST_IDLE: begin
                if (pend_load_q) begin
                    state_d     = ST_LOAD;
                    pend_load_d = 1'b0;
                end else if (pend_dump_q) begin
                    state_d     = ST_DUMP;
                    pend_dump_d = 1'b0;
                end
            end
            ST_LOAD, ST_DUMP: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            pend_load_q  <= 1'b0;
            pend_dump_q  <= 1'b0;
            file_done_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_load_q  <= pend_load_d;
            pend_dump_q  <= pend_dump_d;
            file_done_q  <= (state_q != ST_IDLE);
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            dma_rvalid_q <= dma_gnt & ~dma_we;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_data = cpu_wdata;
            mem_we   = cpu_we;
        end else if (dma_gnt) begin
            mem_addr = dma_addr;
            mem_data = dma_wdata;
            mem_we   = dma_we;
        end
    end

    // Registered outputs are masked during reset so nothing leaks out of the reset cycle.
    always_comb begin
        file_busy      = busy_raw & ~RESET;
        file_done      = file_done_q & ~RESET;
        mem_read_file  = (state_q == ST_LOAD) & ~RESET;
        mem_write_file = (state_q == ST_DUMP) & ~RESET;
        cpu_rvalid     = cpu_rvalid_q & ~RESET;
        dma_rvalid     = dma_rvalid_q & ~RESET;
        cpu_rdata      = cpu_rvalid ? mem_q : '0;
        dma_rdata      = dma_rvalid ? mem_q : '0;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table, directed corner sequences and a random scoreboard.
module tb_data_memory_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          CLK;
    logic          RESET;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          file_load, file_dump, file_busy, file_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_we, mem_read_file, mem_write_file;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .file_load(file_load), .file_dump(file_dump), .file_busy(file_busy),
        .file_done(file_done), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_read_file(mem_read_file), .mem_write_file(mem_write_file), .mem_q(mem_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for data_memory: read_file loads a known image, write_file snapshots it.
    logic [DW-1:0] mem      [1024];
    logic [DW-1:0] dump_img [1024];

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA500_0000 + 32'(a) * 32'd3 + 32'd11;
    endfunction

    always @(posedge CLK) begin
        if (mem_read_file) for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        if (mem_write_file) for (int i = 0; i < 1024; i++) dump_img[i] <= mem[i];
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic drv;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        file_load = 0; file_dump = 0;
    endtask

    typedef struct packed {
        logic cr, cw, dr, dw, eg_c, eg_d;
    } vec_t;
    vec_t tbl [16];

    // Random-phase scoreboard state.
    logic [DW-1:0] ref_mem [16];
    int            streak;
    logic          e_crv, e_drv, e_c, e_d;
    logic [DW-1:0] e_crd, e_drd;

    initial begin : main
        int bad;
        logic got;
        logic [4:0] fexp [7];
        logic [AW-1:0] ea;

        for (int i = 0; i < 12; i++) tbl[i] = '{1, 0, 1, 0, (i % 5) != 4, (i % 5) == 4};
        tbl[12] = '{1, 1, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 1, 1, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 1, 0, 1, 0};

        // Reset with both ports requesting.
        idle_inputs();
        RESET = 1; cpu_req = 1; dma_req = 1;
        for (int k = 0; k < 2; k++) begin
            smp();
            check("reset_flags", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, file_busy,
                                  file_done, mem_we, mem_read_file, mem_write_file}, 0);
            check("reset_bus", mem_addr | mem_data | cpu_rdata | dma_rdata, 0);
            drv();
        end
        RESET = 0;

        // Arbitration table, starting on the first cycle after reset.
        for (int i = 0; i < 16; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = AW'(i); cpu_wdata = 32'(i);
            dma_req = tbl[i].dr; dma_we = tbl[i].dw; dma_addr = AW'(100 + i);
            dma_wdata = 32'(i);
            smp();
            check($sformatf("tbl%0d_gnt", i), {cpu_gnt, dma_gnt}, {tbl[i].eg_c, tbl[i].eg_d});
            ea = tbl[i].eg_c ? AW'(i) : AW'(100 + i);
            if (tbl[i].eg_c || tbl[i].eg_d) begin
                check($sformatf("tbl%0d_addr", i), mem_addr, ea);
                check($sformatf("tbl%0d_we", i), mem_we,
                      (tbl[i].eg_c & tbl[i].cw) | (tbl[i].eg_d & tbl[i].dw));
            end
            drv();
        end

        // CPU write then read back.
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
        smp();
        check("wr5_gnt", {cpu_gnt, mem_we}, 2'b11);
        check("wr5_data", mem_data, 32'hDEADBEEF);
        drv();
        cpu_we = 0;
        smp();
        check("rd5_gnt", {cpu_gnt, mem_we, cpu_rvalid}, 3'b100);
        drv();
        cpu_req = 0;
        smp();
        check("rd5_valid", {cpu_rvalid, dma_rvalid}, 2'b10);
        check("rd5_data", cpu_rdata, 32'hDEADBEEF);
        drv();

        // CPU write followed immediately by DMA read of the same word.
        cpu_req = 1; cpu_we = 1; cpu_addr = 7; cpu_wdata = 32'h0BADF00D;
        smp();
        check("ord_wgnt", cpu_gnt, 1);
        drv();
        idle_inputs();
        dma_req = 1; dma_addr = 7;
        smp();
        check("ord_rgnt", {cpu_gnt, dma_gnt}, 2'b01);
        drv();
        dma_req = 0;
        smp();
        check("ord_valid", {cpu_rvalid, dma_rvalid}, 2'b01);
        check("ord_data", dma_rdata, 32'h0BADF00D);
        drv();

        // Load and dump together while CPU keeps requesting; a late load pulse is absorbed.
        // Fields: cpu_gnt, read_file, write_file, file_done, file_busy.
        fexp = '{5'b10000, 5'b00001, 5'b01001, 5'b00011, 5'b00101, 5'b10010, 5'b10000};
        cpu_req = 1; cpu_we = 0; cpu_addr = 3; file_load = 1; file_dump = 1;
        for (int k = 0; k < 7; k++) begin
            smp();
            check($sformatf("file_c%0d", k),
                  {cpu_gnt, mem_read_file, mem_write_file, file_done, file_busy}, fexp[k]);
            check($sformatf("file_c%0d_dma", k), dma_gnt, 0);
            drv();
            file_load = (k == 1);
            file_dump = 0;
        end
        idle_inputs();

        // Increment sweep over the whole loaded image.
        for (int a = 0; a < 1024; a++) begin
            dma_req = 1; dma_we = 0; dma_addr = AW'(a);
            smp();
            drv();
            dma_we = 1; dma_wdata = pat(a) + 1;
            smp();
            check("sweep_rd", dma_rdata, pat(a));
            check("sweep_wr", {dma_gnt, mem_we}, 2'b11);
            drv();
        end
        idle_inputs();
        file_dump = 1;
        smp();
        drv();
        file_dump = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            smp();
            if (file_done) got = 1;
            drv();
        end
        check("dump_done_seen", got, 1);
        bad = 0;
        for (int a = 0; a < 1024; a++) if (dump_img[a] !== pat(a) + 1) bad++;
        check("dump_words_bad", bad, 0);

        // Random traffic against the scoreboard on addresses 0..15.
        for (int a = 0; a < 16; a++) ref_mem[a] = pat(a) + 1;
        streak = 0; e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0; e_c = 0; e_d = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(cpu_req && !e_c)) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
            end
            if (!(dma_req && !e_d)) begin
                dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
                dma_addr = AW'($urandom_range(0, 15)); dma_wdata = $urandom;
            end
            e_d = dma_req && (streak >= SM || !cpu_req);
            e_c = cpu_req && !e_d;
            smp();
            check("rnd_gnt", {cpu_gnt, dma_gnt}, {e_c, e_d});
            check("rnd_cpu_rd", {31'(0), cpu_rvalid} ^ cpu_rdata, {31'(0), e_crv} ^ e_crd);
            check("rnd_dma_rd", {31'(0), dma_rvalid} ^ dma_rdata, {31'(0), e_drv} ^ e_drd);
            check("rnd_cpu_v", cpu_rvalid, e_crv);
            check("rnd_dma_v", dma_rvalid, e_drv);
            if (e_c || e_d) begin
                check("rnd_addr", mem_addr, e_c ? cpu_addr : dma_addr);
                check("rnd_we", mem_we, e_c ? cpu_we : dma_we);
                if (mem_we) check("rnd_wdata", mem_data, e_c ? cpu_wdata : dma_wdata);
            end
            e_crv = e_c && !cpu_we;
            e_crd = e_crv ? ref_mem[cpu_addr[3:0]] : '0;
            e_drv = e_d && !dma_we;
            e_drd = e_drv ? ref_mem[dma_addr[3:0]] : '0;
            if (e_c && cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
            if (e_d && dma_we) ref_mem[dma_addr[3:0]] = dma_wdata;
            if (!dma_req || e_d) streak = 0;
            else if (e_c && streak < SM) streak++;
            drv();
        end
        idle_inputs();
        smp();
        drv();

        // Reset right after a read grant with a dump pending.
        cpu_req = 1; cpu_we = 0; cpu_addr = 2; file_dump = 1;
        smp();
        check("rst_rdgnt", cpu_gnt, 1);
        drv();
        idle_inputs();
        RESET = 1;
        smp();
        check("rst_drop", {cpu_rvalid, file_busy, mem_write_file}, 0);
        check("rst_rdata", cpu_rdata, 0);
        drv();
        RESET = 0;
        for (int k = 0; k < 4; k++) begin
            smp();
            check($sformatf("rst_after%0d", k),
                  {cpu_rvalid, file_busy, file_done, mem_write_file, mem_read_file}, 0);
            drv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
